// File: rtl/aes_pkg.sv
// Shared AES types, per-mode key-schedule constants and GF(2^8) helpers.
// Pure declarations: no latency, no flow control.
// Imported by the key schedule and by the round datapath.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_POLY   = 8'h1b;

  typedef logic [127:0] aes_128;
  typedef logic [255:0] key_256;

  typedef enum logic [1:0] {
    NOOP    = 2'd0,
    ENC_128 = 2'd1,
    ENC_192 = 2'd2,
    ENC_256 = 2'd3
  } aes_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_t;

  function automatic logic [3:0] nk_of(input aes_mode_t mode);
    case (mode)
      ENC_192: nk_of = 4'd6;
      ENC_256: nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input aes_mode_t mode);
    case (mode)
      ENC_128: nr_of = 4'd10;
      ENC_192: nr_of = 4'd12;
      ENC_256: nr_of = 4'd14;
      default: nr_of = 4'd0;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input aes_mode_t mode);
    case (mode)
      ENC_128: nw_of = 6'd44;
      ENC_192: nw_of = 6'd52;
      ENC_256: nw_of = 6'd60;
      default: nw_of = 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in, one byte out.
// Latency: purely combinational.
// No flow control; shared by the key schedule and the round datapath.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Row-major FIPS-197 table; element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key schedule: one 32-bit word per clock into a local store.
// Latency: keys_ready_o rises Nw-Nk cycles after the accepted start (40/46/52).
// Backpressure: none; start_i is ignored while busy, round keys read combinationally.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = 60
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start_i,
  input  aes_mode_t mode_i,
  input  key_256    key_i,
  input  logic [3:0] rk_idx_i,
  output logic      busy_o,
  output logic      keys_ready_o,
  output aes_128    rk_o
);

  ks_state_t   state_q;
  ks_state_t   state_d;
  aes_mode_t   mode_q;
  logic [31:0] w_q [MAX_WORDS];
  logic [5:0]  i_q;
  logic [2:0]  j_q;
  logic [7:0]  rcon_q;

  logic [3:0]  nk;
  logic [3:0]  nr;
  logic [5:0]  nw;
  logic [3:0]  nk_in;
  logic        accept;
  logic        last_word;

  logic [5:0]  prev_idx;
  logic [5:0]  old_idx;
  logic [31:0] prev_w;
  logic [31:0] old_w;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] new_w;

  assign nk        = nk_of(mode_q);
  assign nr        = nr_of(mode_q);
  assign nw        = nw_of(mode_q);
  assign nk_in     = nk_of(mode_i);
  assign accept    = (state_q != ST_GEN) && start_i && (mode_i != NOOP);
  assign last_word = (i_q == nw - 6'd1);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept) state_d = ST_GEN;
      ST_GEN:           if (last_word) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o       = 1'b0;
    keys_ready_o = 1'b0;
    case (state_q)
      ST_GEN:  busy_o       = 1'b1;
      ST_DONE: keys_ready_o = 1'b1;
      default: ;
    endcase
  end

  // Word generation: w[i] = w[i-Nk] ^ f(w[i-1])
  assign prev_idx = i_q - 6'd1;
  assign old_idx  = i_q - {2'b00, nk};
  assign prev_w   = w_q[prev_idx];
  assign old_w    = w_q[old_idx];
  assign sub_in   = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (sub_in[8*b +: 8]),
      .s_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = prev_w;
    if (j_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nk == 4'd8 && j_q == 3'd4) begin
      temp = sub_out;
    end
  end

  assign new_w = old_w ^ temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_WORDS; k++) w_q[k] <= '0;
      mode_q <= NOOP;
      i_q    <= '0;
      j_q    <= '0;
      rcon_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nk_in) w_q[k] <= key_i[255 - 32*k -: 32];
      end
      mode_q <= mode_i;
      i_q    <= {2'b00, nk_in};
      j_q    <= '0;
      rcon_q <= RCON_INIT;
    end else if (state_q == ST_GEN) begin
      w_q[i_q] <= new_w;
      i_q      <= i_q + 6'd1;
      // j tracks i mod Nk without a divider
      j_q      <= ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
      if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
    end
  end

  // Round-key read port; zero outside the latched mode's range or while not ready
  logic [5:0] base;
  always_comb begin
    base = {rk_idx_i, 2'b00};
    rk_o = '0;
    if (state_q == ST_DONE && rk_idx_i <= nr) begin
      rk_o = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
    end
  end

endmodule
